// File: rtl/vram_arbiter.sv
// Shares one synchronous-read VRAM between display line prefetch (priority) and a CPU req/ack port.
// Optional build macro VRAM_ARB_STATS_EN adds the cpu_stall_count output.
module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int HCOUNT_WIDTH  = 10,
  parameter int VCOUNT_WIDTH  = 10,
  parameter int LINE_WORDS    = 80,
  parameter int LB_ADDR_WIDTH = 8,
  parameter int TRIGGER_H     = 784,
  parameter int V_FIRST       = 35,
  parameter int V_LAST        = 515,
  parameter int V_TOTAL       = 525
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [HCOUNT_WIDTH-1:0]  h_pos,
  input  logic [VCOUNT_WIDTH-1:0]  v_pos,
  input  logic                     vblank,
  input  logic [ADDR_WIDTH-1:0]    frame_base,
  input  logic                     cpu_req,
  input  logic                     cpu_wr,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_ack,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     lb_we,
  output logic [LB_ADDR_WIDTH-1:0] lb_addr,
  output logic [DATA_WIDTH-1:0]    lb_wdata,
  output logic                     fetch_overrun
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]              cpu_stall_count
`endif
);

  localparam int IDX_W = LB_ADDR_WIDTH - 1;
  localparam int CNT_W = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU_ISSUE, S_CPU_DONE, S_FETCH} state_t;

  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_cnt, w_cnt_next, w_cnt_inc, w_cnt_dec;
  logic                     r_pending, w_pending_next;
  logic [ADDR_WIDTH-1:0]    r_start, w_start_next;
  logic [ADDR_WIDTH-1:0]    r_base, w_base_next;
  logic                     r_bank, w_bank_next;
  logic                     r_overrun, w_overrun_next;
  logic                     r_cpu_ack, w_cpu_ack_next;
  logic [DATA_WIDTH-1:0]    r_cpu_rdata, w_cpu_rdata_next;
  logic                     r_mem_en, w_mem_en_next;
  logic                     r_mem_wr, w_mem_wr_next;
  logic [ADDR_WIDTH-1:0]    r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0]    r_mem_wdata, w_mem_wdata_next;
  logic                     r_lb_we, w_lb_we_next;
  logic [LB_ADDR_WIDTH-1:0] r_lb_addr, w_lb_addr_next;
  logic [DATA_WIDTH-1:0]    r_lb_wdata, w_lb_wdata_next;

  logic [VCOUNT_WIDTH:0]    w_v_inc;
  logic [VCOUNT_WIDTH-1:0]  w_v_next;
  logic [VCOUNT_WIDTH-1:0]  w_line;
  logic                     w_trigger;
  logic [ADDR_WIDTH-1:0]    w_line_base;
  logic [ADDR_WIDTH-1:0]    w_line_start;

  // The trigger looks one line ahead: it fetches the line about to become visible.
  assign w_v_inc   = {1'b0, v_pos} + 1'b1;
  assign w_v_next  = (w_v_inc == (VCOUNT_WIDTH+1)'(V_TOTAL)) ? '0 : w_v_inc[VCOUNT_WIDTH-1:0];
  assign w_trigger = (h_pos == HCOUNT_WIDTH'(TRIGGER_H)) &&
                     (w_v_next >= VCOUNT_WIDTH'(V_FIRST)) &&
                     (w_v_next <  VCOUNT_WIDTH'(V_LAST));
  assign w_line    = w_v_next - VCOUNT_WIDTH'(V_FIRST);
  // Line 0 uses the frame_base being latched in this very cycle.
  assign w_line_base  = (w_line == '0) ? frame_base : r_base;
  assign w_line_start = w_line_base + ADDR_WIDTH'(32'(w_line) * LINE_WORDS);

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_dec = r_cnt - 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_pending_next   = r_pending;
    w_start_next     = r_start;
    w_bank_next      = r_bank;
    w_base_next      = r_base;
    w_overrun_next   = r_overrun;
    w_cpu_ack_next   = 1'b0;
    w_cpu_rdata_next = r_cpu_rdata;
    w_mem_en_next    = 1'b0;
    w_mem_wr_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_lb_we_next     = 1'b0;
    w_lb_addr_next   = r_lb_addr;
    w_lb_wdata_next  = r_lb_wdata;

    if (w_trigger) begin
      if (r_state == S_FETCH || r_pending) begin
        w_overrun_next = 1'b1;
      end else begin
        w_pending_next = 1'b1;
        w_start_next   = w_line_start;
        w_bank_next    = w_line[0];
        if (w_line == '0) w_base_next = frame_base;
      end
    end

    unique case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_next    = S_FETCH;
          w_pending_next  = 1'b0;
          w_cnt_next      = '0;
          w_mem_en_next   = 1'b1;
          w_mem_addr_next = r_start;
        // r_cpu_ack blocks a re-grant while the requester is still seeing its ack.
        end else if (cpu_req && !r_cpu_ack && !w_trigger) begin
          w_state_next     = S_CPU_ISSUE;
          w_mem_en_next    = 1'b1;
          w_mem_wr_next    = cpu_wr;
          w_mem_addr_next  = cpu_addr;
          w_mem_wdata_next = cpu_wdata;
        end
      end
      S_CPU_ISSUE: begin
        w_state_next = S_CPU_DONE;
      end
      S_CPU_DONE: begin
        w_state_next   = S_IDLE;
        w_cpu_ack_next = 1'b1;
        if (!cpu_wr) w_cpu_rdata_next = mem_rdata;
      end
      S_FETCH: begin
        // Read r_cnt is on the bus now; read r_cnt-1 returns its data this cycle.
        if (r_cnt < CNT_W'(LINE_WORDS - 1)) begin
          w_mem_en_next   = 1'b1;
          w_mem_addr_next = r_start + ADDR_WIDTH'(w_cnt_inc);
        end
        if (r_cnt != '0) begin
          w_lb_we_next    = 1'b1;
          w_lb_addr_next  = {r_bank, IDX_W'(w_cnt_dec)};
          w_lb_wdata_next = mem_rdata;
        end
        if (r_cnt == CNT_W'(LINE_WORDS)) w_state_next = S_IDLE;
        w_cnt_next = w_cnt_inc;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_start     <= '0;
      r_bank      <= 1'b0;
      r_base      <= '0;
      r_overrun   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_lb_we     <= 1'b0;
      r_lb_addr   <= '0;
      r_lb_wdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_pending   <= w_pending_next;
      r_start     <= w_start_next;
      r_bank      <= w_bank_next;
      r_base      <= w_base_next;
      r_overrun   <= w_overrun_next;
      r_cpu_ack   <= w_cpu_ack_next;
      r_cpu_rdata <= w_cpu_rdata_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_wr    <= w_mem_wr_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_lb_we     <= w_lb_we_next;
      r_lb_addr   <= w_lb_addr_next;
      r_lb_wdata  <= w_lb_wdata_next;
    end
  end

  assign cpu_ack       = r_cpu_ack;
  assign cpu_rdata     = r_cpu_rdata;
  assign mem_en        = r_mem_en;
  assign mem_wr        = r_mem_wr;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign lb_we         = r_lb_we;
  assign lb_addr       = r_lb_addr;
  assign lb_wdata      = r_lb_wdata;
  assign fetch_overrun = r_overrun;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_count;
  logic        r_vblank_d;

  // Counts cycles a pending CPU request waits; restarts at each vblank rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_vblank_d    <= 1'b0;
    end else begin
      r_vblank_d <= vblank;
      if (vblank && !r_vblank_d) begin
        r_stall_count <= '0;
      end else if (cpu_req && (r_state == S_IDLE || r_state == S_FETCH) &&
                   (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign cpu_stall_count = r_stall_count;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
`endif

endmodule
